// File: rtl/pagerank_mem_arb_pkg.sv
// Shared message widths, field positions and tag definitions for the
// pageRank two-requester memory arbiter.
package pagerank_mem_arb_pkg;

    // Memory request message: {type_[3], opaque[8], addr[32], len[2], data[32]}
    localparam int MEM_REQ_W       = 77;
    localparam int MEM_REQ_DATA_LSB = 0;
    localparam int MEM_REQ_LEN_LSB  = 32;
    localparam int MEM_REQ_ADDR_LSB = 34;
    localparam int MEM_REQ_OPQ_LSB  = 66;
    localparam int MEM_REQ_TYPE_LSB = 74;

    // Memory response message: {type_[3], opaque[8], test[2], len[2], data[32]}
    localparam int MEM_RESP_W        = 47;
    localparam int MEM_RESP_DATA_LSB = 0;
    localparam int MEM_RESP_LEN_LSB  = 32;
    localparam int MEM_RESP_TEST_LSB = 34;
    localparam int MEM_RESP_OPQ_LSB  = 36;
    localparam int MEM_RESP_TYPE_LSB = 44;

    // Requester identity stored per outstanding request
    localparam int ID_W          = 1;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [ID_W-1:0] {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/pagerank_tag_fifo.sv
// Small FIFO holding the requester ID of every issued-but-unanswered
// memory request. Full/empty come from the registered count only.
module pagerank_tag_fifo
    import pagerank_mem_arb_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [ID_W-1:0] push_data,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    logic [ID_W-1:0] entries [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Tag storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) entries[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pagerank_mem_arb.sv
// Round-robin arbiter sharing one in-order memory port between two
// requesters. Requests pass through combinationally; each issued request
// leaves its requester ID in a tag FIFO so the in-order responses can be
// steered back to whoever asked.
module pagerank_mem_arb
    import pagerank_mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [MEM_REQ_W-1:0]    req0_msg,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [MEM_REQ_W-1:0]    req1_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,

    output logic [MEM_RESP_W-1:0]   resp0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [MEM_RESP_W-1:0]   resp1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,

    output logic [MEM_REQ_W-1:0]    mem_req_msg,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    input  logic [MEM_RESP_W-1:0]   mem_resp_msg,
    input  logic                    mem_resp_val,
    output logic                    mem_resp_rdy,

    output logic [$clog2(DEPTH):0]  outstanding
);

    req_id_e         ptr;
    req_id_e         grant;
    logic            grant_val;
    logic            req_fire;
    logic            resp_fire;
    logic            full;
    logic            empty;
    logic [ID_W-1:0] head;

    // Pick the preferred requester if it is asking, otherwise the other one
    always_comb begin
        grant     = ptr;
        grant_val = 1'b0;
        if (ptr == REQ0) begin
            if (req0_val) begin
                grant     = REQ0;
                grant_val = 1'b1;
            end else if (req1_val) begin
                grant     = REQ1;
                grant_val = 1'b1;
            end
        end else begin
            if (req1_val) begin
                grant     = REQ1;
                grant_val = 1'b1;
            end else if (req0_val) begin
                grant     = REQ0;
                grant_val = 1'b1;
            end
        end
    end

    // Request path: the granted message goes out untouched; a full tag FIFO
    // blocks issue even if a response pops an entry in the same cycle
    assign mem_req_msg = (grant == REQ1) ? req1_msg : req0_msg;
    assign mem_req_val = grant_val && !full;
    assign req0_rdy    = grant_val && (grant == REQ0) && mem_req_rdy && !full;
    assign req1_rdy    = grant_val && (grant == REQ1) && mem_req_rdy && !full;
    assign req_fire    = mem_req_val && mem_req_rdy;

    // Response path: the FIFO head names the requester this response belongs
    // to; with nothing outstanding a response is stalled, never dropped
    assign resp0_msg    = mem_resp_msg;
    assign resp1_msg    = mem_resp_msg;
    assign resp0_val    = mem_resp_val && !empty && (head == REQ0);
    assign resp1_val    = mem_resp_val && !empty && (head == REQ1);
    assign mem_resp_rdy = !empty && ((head == REQ1) ? resp1_rdy : resp0_rdy);
    assign resp_fire    = mem_resp_val && mem_resp_rdy;

    // Hand priority to the other requester after every issued request
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= REQ0;
        end else if (req_fire) begin
            ptr <= (grant == REQ0) ? REQ1 : REQ0;
        end
    end

    pagerank_tag_fifo #(
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (grant),
        .pop       (resp_fire),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (outstanding)
    );

endmodule

// File: tb/tb_pagerank_mem_arb.sv
// Self-checking bench for pagerank_mem_arb: directed scenarios plus a
// randomized run against a queue-based model of the outstanding requests.
module tb_pagerank_mem_arb;
    import pagerank_mem_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [MEM_REQ_W-1:0]  req0_msg, req1_msg, mem_req_msg;
    logic                  req0_val, req0_rdy, req1_val, req1_rdy;
    logic [MEM_RESP_W-1:0] resp0_msg, resp1_msg, mem_resp_msg;
    logic                  resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic                  mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
    logic [CW-1:0]         outstanding;

    always #5 clk = ~clk;

    pagerank_mem_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
        .mem_resp_msg(mem_resp_msg), .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
        .outstanding(outstanding)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who has priority, and the ordered list of requesters
    // still waiting for a response
    int m_ptr = 0;
    int m_q[$];

    int                   e_g;
    logic                 e_req_val, e_req0_rdy, e_req1_rdy;
    logic                 e_resp0_val, e_resp1_val, e_mem_resp_rdy;
    logic [MEM_REQ_W-1:0] e_req_msg;
    logic [CW-1:0]        e_out;

    function automatic logic [MEM_REQ_W-1:0] rand_req();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[MEM_REQ_W-1:0];
    endfunction

    function automatic logic [MEM_RESP_W-1:0] rand_resp();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[MEM_RESP_W-1:0];
    endfunction

    task automatic compute_expected();
        bit v[2];
        bit full, empty;
        int head;
        v[0] = req0_val;
        v[1] = req1_val;
        e_g = -1;
        if (v[m_ptr]) e_g = m_ptr;
        else if (v[1 - m_ptr]) e_g = 1 - m_ptr;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        e_req_val  = (e_g >= 0) && !full;
        e_req_msg  = (e_g == 1) ? req1_msg : req0_msg;
        e_req0_rdy = (e_g == 0) && mem_req_rdy && !full;
        e_req1_rdy = (e_g == 1) && mem_req_rdy && !full;
        head = empty ? 0 : m_q[0];
        e_resp0_val    = mem_resp_val && !empty && (head == 0);
        e_resp1_val    = mem_resp_val && !empty && (head == 1);
        e_mem_resp_rdy = !empty && ((head == 1) ? resp1_rdy : resp0_rdy);
        e_out = CW'(m_q.size());
    endtask

    // One clock: model follows the handshakes seen on the current inputs
    task automatic advance();
        bit rq, rs;
        compute_expected();
        rq = e_req_val && mem_req_rdy;
        rs = mem_resp_val && e_mem_resp_rdy;
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_ptr = 0;
        end else begin
            if (rs) void'(m_q.pop_front());
            if (rq) begin
                m_q.push_back(e_g);
                m_ptr = 1 - e_g;
            end
        end
        #1;
    endtask

    task automatic idle();
        req0_val = 0; req1_val = 0; mem_req_rdy = 0;
        mem_resp_val = 0; resp0_rdy = 0; resp1_rdy = 0;
        req0_msg = rand_req(); req1_msg = rand_req(); mem_resp_msg = rand_resp();
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        advance();
        advance();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_checks++; if (outstanding !== '0) begin n_fail++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        n_checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b000) begin n_fail++; $display("FAIL reset_resp got %b want 000", {resp0_val, resp1_val, mem_resp_rdy}); end
        n_checks++; if ({req0_rdy, req1_rdy, mem_req_val} !== 3'b101) begin n_fail++; $display("FAIL reset_grant got %b want 101", {req0_rdy, req1_rdy, mem_req_val}); end
        idle();
    endtask

    task automatic test_single();
        do_reset();
        req0_msg = {3'd0, 8'h5A, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF};
        req0_val = 1; mem_req_rdy = 1;
        #1;
        n_checks++; if (mem_req_msg !== req0_msg || mem_req_val !== 1'b1) begin n_fail++; $display("FAIL single_fwd got %h/%b want %h/1", mem_req_msg, mem_req_val, req0_msg); end
        n_checks++; if (outstanding !== 0) begin n_fail++; $display("FAIL single_out0 got %0d want 0", outstanding); end
        advance();
        req0_val = 0;
        #1;
        n_checks++; if (outstanding !== 1) begin n_fail++; $display("FAIL single_out1 got %0d want 1", outstanding); end
        mem_resp_val = 1; mem_resp_msg = rand_resp(); resp0_rdy = 1;
        #1;
        n_checks++; if ({resp0_val, resp1_val, mem_resp_rdy} !== 3'b101 || resp0_msg !== mem_resp_msg) begin n_fail++; $display("FAIL single_resp got %b %h want 101 %h", {resp0_val, resp1_val, mem_resp_rdy}, resp0_msg, mem_resp_msg); end
        advance();
        idle();
        #1;
        n_checks++; if (outstanding !== 0) begin n_fail++; $display("FAIL single_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_alternate();
        int issued[$];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req0_val = 1; req1_val = 1; mem_req_rdy = 1;
            req0_msg = rand_req(); req1_msg = rand_req();
            mem_resp_val = (i > 0); mem_resp_msg = rand_resp();
            resp0_rdy = 1; resp1_rdy = 1;
            #1;
            n_checks++;
            if (mem_req_msg !== ((i % 2) ? req1_msg : req0_msg) || {req1_rdy, req0_rdy} !== ((i % 2) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL alt_grant cycle %0d got rdy %b want grant %0d", i, {req1_rdy, req0_rdy}, i % 2);
            end
            if (i > 0) begin
                n_checks++;
                if ({resp1_val, resp0_val} !== ((issued[0] == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL alt_route cycle %0d got %b want id %0d", i, {resp1_val, resp0_val}, issued[0]);
                end
                void'(issued.pop_front());
            end
            issued.push_back(i % 2);
            advance();
        end
        idle();
    endtask

    task automatic test_full();
        do_reset();
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            req0_msg = rand_req(); req1_msg = rand_req();
            advance();
        end
        #1;
        n_checks++; if (outstanding !== DEPTH) begin n_fail++; $display("FAIL full_count got %0d want %0d", outstanding, DEPTH); end
        n_checks++; if ({req0_rdy, req1_rdy, mem_req_val} !== 3'b000) begin n_fail++; $display("FAIL full_block got %b want 000", {req0_rdy, req1_rdy, mem_req_val}); end
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_checks++; if (mem_resp_rdy !== 1'b1 || mem_req_val !== 1'b0) begin n_fail++; $display("FAIL full_samecycle got resp_rdy %b req_val %b want 1 0", mem_resp_rdy, mem_req_val); end
        advance();
        mem_resp_val = 0;
        #1;
        n_checks++; if (outstanding !== DEPTH - 1 || mem_req_val !== 1'b1) begin n_fail++; $display("FAIL full_next got %0d/%b want %0d/1", outstanding, mem_req_val, DEPTH - 1); end
        advance();
        n_checks++; if (outstanding !== DEPTH) begin n_fail++; $display("FAIL full_refill got %0d want %0d", outstanding, DEPTH); end
        idle();
    endtask

    task automatic test_head_stall();
        do_reset();
        req1_val = 1; mem_req_rdy = 1;
        advance();
        idle();
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({mem_resp_rdy, resp0_val, resp1_val} !== 3'b001 || outstanding !== 1) begin
                n_fail++; $display("FAIL stall cycle %0d got %b out %0d want 001 out 1", i, {mem_resp_rdy, resp0_val, resp1_val}, outstanding);
            end
            advance();
        end
        resp1_rdy = 1;
        #1;
        n_checks++; if (mem_resp_rdy !== 1'b1 || resp1_msg !== mem_resp_msg) begin n_fail++; $display("FAIL stall_release got %b %h want 1 %h", mem_resp_rdy, resp1_msg, mem_resp_msg); end
        advance();
        idle();
        #1;
        n_checks++; if (outstanding !== 0) begin n_fail++; $display("FAIL stall_drain got %0d want 0", outstanding); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req0_val = 1; mem_req_rdy = 1;
        for (int i = 0; i < 3; i++) advance();
        req0_val = 0;
        #1;
        n_checks++; if (outstanding !== 3) begin n_fail++; $display("FAIL rmid_pre got %0d want 3", outstanding); end
        reset = 1;
        advance();
        reset = 0;
        idle();
        mem_resp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_checks++; if (outstanding !== 0 || {mem_resp_rdy, resp0_val, resp1_val} !== 3'b000) begin n_fail++; $display("FAIL rmid_stray got out %0d %b want 0 000", outstanding, {mem_resp_rdy, resp0_val, resp1_val}); end
        req0_val = 1; req1_val = 1; mem_req_rdy = 1;
        #1;
        n_checks++; if ({req0_rdy, req1_rdy} !== 2'b10 || mem_req_msg !== req0_msg) begin n_fail++; $display("FAIL rmid_ptr got %b want 10", {req0_rdy, req1_rdy}); end
        advance();
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req0_val = $urandom_range(0, 1); req1_val = $urandom_range(0, 1);
            mem_req_rdy = ($urandom_range(0, 3) != 0);
            mem_resp_val = $urandom_range(0, 1);
            resp0_rdy = ($urandom_range(0, 3) != 0); resp1_rdy = ($urandom_range(0, 3) != 0);
            req0_msg = rand_req(); req1_msg = rand_req(); mem_resp_msg = rand_resp();
            #1;
            compute_expected();
            n_checks++;
            if ({mem_req_val, req0_rdy, req1_rdy} !== {e_req_val, e_req0_rdy, e_req1_rdy} || (e_req_val && mem_req_msg !== e_req_msg)) begin
                n_fail++; $display("FAIL rand_req cycle %0d got %b want %b", i, {mem_req_val, req0_rdy, req1_rdy}, {e_req_val, e_req0_rdy, e_req1_rdy});
            end
            n_checks++;
            if ({resp0_val, resp1_val, mem_resp_rdy} !== {e_resp0_val, e_resp1_val, e_mem_resp_rdy} || resp0_msg !== mem_resp_msg || resp1_msg !== mem_resp_msg) begin
                n_fail++; $display("FAIL rand_resp cycle %0d got %b want %b", i, {resp0_val, resp1_val, mem_resp_rdy}, {e_resp0_val, e_resp1_val, e_mem_resp_rdy});
            end
            n_checks++;
            if (outstanding !== e_out) begin
                n_fail++; $display("FAIL rand_count cycle %0d got %0d want %0d", i, outstanding, e_out);
            end
            advance();
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_single();
        test_alternate();
        test_full();
        test_head_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pagerank_mem_arb.md
PAGERANK_MEM_ARB -- requirements
Module: pagerank_mem_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the outstanding-request tag FIFO depth (power of two, >=2).
REQ-002 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req0_msg  in  77  requester 0 memory request {type_[3],opaque[8],addr[32],len[2],data[32]}.
REQ-004 SHALL have ports: req0_val  in  1  requester 0 valid; req0_rdy  out  1  requester 0 ready.
REQ-005 SHALL have port: req1_msg  in  77  requester 1 memory request, same format.
REQ-006 SHALL have ports: req1_val  in  1  requester 1 valid; req1_rdy  out  1  requester 1 ready.
REQ-007 SHALL have ports: resp0_msg  out  47  response to requester 0 {type_[3],opaque[8],test[2],len[2],data[32]}; resp0_val  out  1; resp0_rdy  in  1.
REQ-008 SHALL have ports: resp1_msg  out  47  response to requester 1; resp1_val  out  1; resp1_rdy  in  1.
REQ-009 SHALL have ports: mem_req_msg  out  77; mem_req_val  out  1; mem_req_rdy  in  1  shared memory request port.
REQ-010 SHALL have ports: mem_resp_msg  in  47; mem_resp_val  in  1; mem_resp_rdy  out  1  shared memory response port.
REQ-011 SHALL have port: outstanding  out  $clog2(DEPTH)+1  count of requests issued but not yet answered.

Function
REQ-012 SHALL arbitrate requesters 0/1 onto the memory request port round-robin; priority pointer ptr selects the preferred requester.
REQ-013 SHALL grant the requester at ptr if its val is high, else the other if its val is high; no grant when neither valid.
REQ-014 SHALL forward the granted message unmodified (opaque untouched) combinationally: zero-cycle latency.
REQ-015 SHALL drive mem_req_val = granted val AND NOT full; reqN_rdy = (grant==N) AND mem_req_rdy AND NOT full; non-granted rdy = 0.
REQ-016 SHALL, on mem request fire (val&&rdy), push the granted ID into the tag FIFO and set ptr to the other requester next cycle; ptr unchanged otherwise.
REQ-017 SHALL route each memory response to the requester at tag-FIFO head (memory returns in order); message passed through unmodified.
REQ-018 SHALL drive respN_val = mem_resp_val AND NOT empty AND head==N; mem_resp_rdy = NOT empty AND rdy of head requester.
REQ-019 SHALL pop the tag FIFO on mem response fire.
REQ-020 SHALL compute full/empty from the registered count only: a same-cycle pop does NOT unblock a request when full.
REQ-021 SHALL allow simultaneous push and pop when neither full nor empty; count unchanged, both pointers advance.
REQ-022 SHALL wrap FIFO read/write pointers modulo DEPTH.
REQ-023 SHALL hold mem_resp_rdy = 0 when empty (stray response stalls, never dropped or misrouted).
REQ-024 SHALL drive outstanding = registered FIFO count.

Reset
REQ-025 SHALL on reset set ptr=0, FIFO pointers=0, count=0; hence all rdy/val outputs 0 except those enabled by inputs per REQ-015/018 (resp vals 0).
REQ-026 SHALL, on reset mid-operation, discard all outstanding tags; responses arriving afterwards stall per REQ-023.

Structure
REQ-027 SHALL take message widths and field macros from the shared mem-msgs package; ID width and DEPTH default belong in the pageRank-msgs package.
REQ-028 SHALL instantiate one sub-module pagerank_tag_fifo (1-bit data, DEPTH entries, count output).

Verification
REQ-029 Only req0 valid, addr 0x100, mem_req_rdy=1 -> mem_req_msg==req0_msg same cycle, outstanding 0->1, response routed to resp0.
REQ-030 Both valid continuously, mem always ready, DEPTH=4, responses returned 1 cycle later -> grants alternate 0,1,0,1; each response reaches issuing requester.
REQ-031 Issue 4 requests with no responses -> outstanding=4, req0_rdy=req1_rdy=0, mem_req_val=0 on 5th; response then popping -> 5th issues the following cycle, not same cycle.
REQ-032 Head=1, resp1_rdy=0, mem_resp_val=1 -> mem_resp_rdy=0, resp0_val=0, message held until resp1_rdy=1.
REQ-033 Reset asserted with 3 outstanding, then mem_resp_val=1 -> outstanding=0, mem_resp_rdy=0, no resp val; ptr=0 grants req0 first.
